// File: rtl/cim_sched_pkg.sv
// Shared types and constants for the CIM S-box scheduler.
package cim_sched_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, LOOKUP, WAIT, RESP} state_e;
    typedef enum logic {SRC_DATA = 1'b0, SRC_KEY = 1'b1} src_e;

    localparam int DATA_ISSUE = 8;
    localparam int KEY_ISSUE  = 2;
    localparam int LANES      = 16;

    // Byte pair {byte 2k, byte 2k+1}; byte0 sits in the top byte.
    function automatic logic [15:0] lane_pair(input logic [LANES*8-1:0] data, input logic [2:0] k);
        return data[LANES*8-1 - 16*int'(k) -: 16];
    endfunction

endpackage

// File: rtl/cim_rr_arb.sv
// Two-way round-robin arbiter: bit0 = datapath, bit1 = key.
module cim_rr_arb (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;  // 1 = key favoured on a tie

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ptr_q;
        // The source just served loses the next tie.
        if (advance) ptr_d = grant[0];
    end

    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= 1'b1;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cim_sbox_scheduler.sv
// Time-shares one CIM S-box macro between SubBytes (16 B) and SubWord (4 B) requests.
module cim_sbox_scheduler
    import cim_sched_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int LANES  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 dreq_vld,
    output logic                 dreq_rdy,
    input  logic [LANES*8-1:0]   dreq_data,
    input  logic                 kreq_vld,
    output logic                 kreq_rdy,
    input  logic [31:0]          kreq_data,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic                 rsp_src,
    output logic [LANES*8-1:0]   rsp_data,
    output logic                 cim_we,
    output logic [3:0]           cim_lane,
    output logic [15:0]          cim_in,
    output logic                 cim_rd,
    input  logic [LANES*8-1:0]   cim_rio,
    output logic                 busy
);

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [LANES*8-1:0] pay_q, pay_d, rsp_data_q, rsp_data_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               cim_we_q, cim_we_d, cim_rd_q, cim_rd_d, rsp_vld_q, rsp_vld_d;
    logic [3:0]         cim_lane_q, cim_lane_d;
    logic [15:0]        cim_in_q, cim_in_d;
    logic [1:0]         grant;
    logic               idle, hs;
    logic [2:0]         last_issue;

    assign idle     = (state_q == IDLE) && !RST;
    assign dreq_rdy = idle & grant[0];
    assign kreq_rdy = idle & grant[1];
    assign hs       = dreq_rdy | kreq_rdy;

    cim_rr_arb u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     ({kreq_vld, dreq_vld}),
        .advance (hs),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        pay_d      = pay_q;
        cnt_d      = cnt_q;
        cim_we_d   = 1'b0;
        cim_lane_d = '0;
        cim_in_d   = '0;
        cim_rd_d   = 1'b0;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        last_issue = (src_q == SRC_KEY) ? 3'(KEY_ISSUE - 1) : 3'(DATA_ISSUE - 1);
        // Strobes are registered, so each state sets up the next cycle's bus values.
        case (state_q)
            IDLE: if (hs) begin
                src_d    = kreq_rdy ? SRC_KEY : SRC_DATA;
                pay_d    = kreq_rdy ? {kreq_data, {(LANES*8-32){1'b0}}} : dreq_data;
                cnt_d    = '0;
                state_d  = ISSUE;
                cim_we_d = 1'b1;
                cim_in_d = lane_pair(pay_d, 3'd0);
            end
            ISSUE: if (cnt_q == last_issue) begin
                state_d  = LOOKUP;
                cim_rd_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d      = cnt_q + 3'd1;
                cim_we_d   = 1'b1;
                cim_lane_d = {cnt_d, 1'b0};
                cim_in_d   = lane_pair(pay_q, cnt_d);
            end
            LOOKUP: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (cnt_q == 3'(RD_LAT - 1)) begin
                state_d    = RESP;
                rsp_vld_d  = 1'b1;
                rsp_data_d = (src_q == SRC_KEY) ? {cim_rio[LANES*8-1 -: 32], {(LANES*8-32){1'b0}}}
                                                : cim_rio;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            RESP: if (rsp_rdy) begin
                state_d   = IDLE;
                rsp_vld_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            src_q      <= SRC_DATA;
            pay_q      <= '0;
            cnt_q      <= '0;
            cim_we_q   <= 1'b0;
            cim_lane_q <= '0;
            cim_in_q   <= '0;
            cim_rd_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            pay_q      <= pay_d;
            cnt_q      <= cnt_d;
            cim_we_q   <= cim_we_d;
            cim_lane_q <= cim_lane_d;
            cim_in_q   <= cim_in_d;
            cim_rd_q   <= cim_rd_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign cim_we   = cim_we_q;
    assign cim_lane = cim_lane_q;
    assign cim_in   = cim_in_q;
    assign cim_rd   = cim_rd_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_src  = src_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cim_sbox_scheduler.sv
// Bench for cim_sbox_scheduler: AES S-box macro model, transaction-timeline reference, random traffic.
module tb_cim_sbox_scheduler;

    localparam int RD_LAT = 3;

    logic         CLK = 1'b0, RST = 1'b1;
    logic         dreq_vld = 1'b0, dreq_rdy;
    logic [127:0] dreq_data = '0;
    logic         kreq_vld = 1'b0, kreq_rdy;
    logic [31:0]  kreq_data = '0;
    logic         rsp_vld, rsp_rdy = 1'b1, rsp_src;
    logic [127:0] rsp_data;
    logic         cim_we, cim_rd, busy;
    logic [3:0]   cim_lane;
    logic [15:0]  cim_in;
    logic [127:0] cim_rio;

    always #5 CLK = ~CLK;

    cim_sbox_scheduler #(.RD_LAT(RD_LAT), .LANES(16)) dut (
        .CLK(CLK), .RST(RST),
        .dreq_vld(dreq_vld), .dreq_rdy(dreq_rdy), .dreq_data(dreq_data),
        .kreq_vld(kreq_vld), .kreq_rdy(kreq_rdy), .kreq_data(kreq_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_src(rsp_src), .rsp_data(rsp_data),
        .cim_we(cim_we), .cim_lane(cim_lane), .cim_in(cim_in), .cim_rd(cim_rd),
        .cim_rio(cim_rio), .busy(busy)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] sbox [256];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            b = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input int nb);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < nb; j++) r[127-8*j -: 8] = sbox[v[127-8*j -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Macro model: lanes written on cim_we, readback valid exactly RD_LAT cycles after cim_rd.
    logic [7:0]   lanes [16] = '{default: 8'h00};
    logic [7:0]   rd_hist = '0;
    logic [127:0] noise = '0;

    always @(posedge CLK) begin
        if (cim_we) begin
            lanes[cim_lane]        <= cim_in[15:8];
            lanes[cim_lane + 4'd1] <= cim_in[7:0];
        end
        rd_hist <= {rd_hist[6:0], cim_rd};
        noise   <= rnd128();
    end

    always_comb begin
        cim_rio = noise;
        if (rd_hist[RD_LAT-1])
            for (int j = 0; j < 16; j++) cim_rio[127-8*j -: 8] = sbox[lanes[j]];
    end

    // Reference: one transaction timeline anchored on the handshake cycle.
    initial begin : cmp
        logic m_busy, m_src, m_ptr_key, ek, ed;
        int m_t, m_n, d;
        logic [127:0] m_pay, m_exp;
        m_busy = 1'b0; m_src = 1'b0; m_ptr_key = 1'b1;
        m_t = 0; m_n = 0; m_pay = '0; m_exp = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rdy_during_reset", {dreq_rdy, kreq_rdy}, 0);
                m_busy = 1'b0;
                m_ptr_key = 1'b1;
            end else if (!m_busy) begin
                ek = kreq_vld && (!dreq_vld || m_ptr_key);
                ed = dreq_vld && !ek;
                chk("kreq_rdy", kreq_rdy, ek);
                chk("dreq_rdy", dreq_rdy, ed);
                chk("idle_outputs", {busy, cim_we, cim_rd, rsp_vld}, 0);
                if (ek || ed) begin
                    m_busy    = 1'b1;
                    m_t       = cyc;
                    m_src     = ek;
                    m_pay     = ek ? {kreq_data, 96'h0} : dreq_data;
                    m_n       = ek ? 2 : 8;
                    m_exp     = sub_bytes(m_pay, ek ? 4 : 16);
                    m_ptr_key = !ek;
                end
            end else begin
                d = cyc - m_t;
                chk("rdy_while_busy", {dreq_rdy, kreq_rdy}, 0);
                chk("busy", busy, 1);
                chk("cim_we", cim_we, d <= m_n);
                if (d <= m_n) begin
                    chk("cim_lane", cim_lane, 2*(d-1));
                    chk("cim_in", cim_in, m_pay[127-16*(d-1) -: 16]);
                end
                chk("cim_rd", cim_rd, d == m_n + 1);
                chk("rsp_vld", rsp_vld, d >= m_n + 2 + RD_LAT);
                if (d >= m_n + 2 + RD_LAT) begin
                    chk("rsp_data", rsp_data, m_exp);
                    chk("rsp_src", rsp_src, m_src);
                    if (rsp_rdy) m_busy = 1'b0;
                end
            end
        end
    end

    logic s_dh, s_kh, s_rv, s_rsrc, s_busy, s_drdy;
    logic [127:0] s_rdata;
    int s_cyc;

    task automatic tick();
        @(negedge CLK);
        s_dh = dreq_vld & dreq_rdy;  s_kh = kreq_vld & kreq_rdy;
        s_rv = rsp_vld;  s_rdata = rsp_data;  s_rsrc = rsp_src;
        s_busy = busy;  s_drdy = dreq_rdy;  s_cyc = cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++; n_bad++;
        $display("FAIL %s: bound of 200 cycles expired at cycle %0d", nm, cyc);
    endtask

    task automatic wait_hs(input bit key, output int t);
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            tick();
            if (key ? s_kh : s_dh) t = s_cyc;
        end
        if (t < 0) bound_fail("handshake_wait");
    endtask

    task automatic wait_rsp(output int r);
        r = -1;
        for (int i = 0; i < 200 && r < 0; i++) begin
            tick();
            if (s_rv) r = s_cyc;
        end
        if (r < 0) bound_fail("response_wait");
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = !s_busy;
        end
        if (!done) bound_fail("idle_wait");
    endtask

    task automatic zero_chk(input string nm);
        @(negedge CLK);
        chk(nm, {dreq_rdy, kreq_rdy, rsp_vld, rsp_src, cim_we, cim_rd, busy, cim_lane, cim_in}, 0);
        chk(nm, rsp_data, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, r, quiet;
        int g[$];
        logic [127:0] held;

        repeat (3) tick();
        RST = 1'b0;
        zero_chk("reset_values");

        // Datapath request with the FIPS-197 style vector
        dreq_data = 128'h00102030405060708090a0b0c0d0e0f0;
        dreq_vld  = 1'b1;
        wait_hs(1'b0, t);
        dreq_vld = 1'b0;
        wait_rsp(r);
        chk("s1_latency", r - t, 10 + RD_LAT);
        chk("s1_data", s_rdata, 128'h63cab7040953d051cd60e0e7ba70e18c);
        chk("s1_src", s_rsrc, 0);

        // Key SubWord request
        kreq_data = 32'hcf4f3c09;
        kreq_vld  = 1'b1;
        wait_hs(1'b1, t);
        kreq_vld = 1'b0;
        wait_rsp(r);
        chk("s2_latency", r - t, 4 + RD_LAT);
        chk("s2_data", s_rdata, {32'h8a84eb01, 96'h0});
        chk("s2_src", s_rsrc, 1);

        // Both requesters asserted through reset: grants must alternate starting with key
        wait_idle();
        dreq_vld = 1'b1; dreq_data = rnd128();
        kreq_vld = 1'b1; kreq_data = $urandom;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 400 && g.size() < 8; i++) begin
            tick();
            if (s_kh) begin g.push_back(1); kreq_data = $urandom; end
            if (s_dh) begin g.push_back(0); dreq_data = rnd128(); end
        end
        dreq_vld = 1'b0; kreq_vld = 1'b0;
        if (g.size() < 8) bound_fail("s3_grants");
        foreach (g[i]) chk($sformatf("s3_grant%0d", i), g[i], (i % 2 == 0));

        // Response back-pressure with a second datapath request pending
        wait_idle();
        rsp_rdy = 1'b0;
        dreq_vld = 1'b1; dreq_data = rnd128();
        wait_hs(1'b0, t);
        dreq_data = rnd128();
        wait_rsp(r);
        held = s_rdata;
        repeat (5) begin
            tick();
            chk("s4_vld_held", s_rv, 1);
            chk("s4_data_held", s_rdata, held);
            chk("s4_dreq_rdy_low", s_drdy, 0);
        end
        rsp_rdy = 1'b1;
        tick();
        chk("s4_accept_cycle_rdy", s_drdy, 0);
        tick();
        chk("s4_regrant_next_cycle", s_dh, 1);
        dreq_vld = 1'b0;

        // Reset in the 4th issue cycle drops the request
        wait_idle();
        dreq_vld = 1'b1; dreq_data = rnd128();
        wait_hs(1'b0, t);
        dreq_vld = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        zero_chk("s5_after_reset");
        quiet = 0;
        repeat (20) begin
            tick();
            if (s_rv) quiet++;
        end
        chk("s5_no_response", quiet, 0);
        dreq_vld = 1'b1; kreq_vld = 1'b1;
        tick();
        chk("s5_key_first", {s_kh, s_dh}, 2'b10);
        dreq_vld = 1'b0; kreq_vld = 1'b0;

        // Random traffic with occasional resets
        wait_idle();
        for (int i = 0; i < 3000; i++) begin
            tick();
            RST = ($urandom_range(299) == 0);
            if (s_dh || !dreq_vld) begin
                dreq_vld  = ($urandom_range(2) == 0);
                dreq_data = rnd128();
            end
            if (s_kh || !kreq_vld) begin
                kreq_vld  = ($urandom_range(2) == 0);
                kreq_data = $urandom;
            end
            rsp_rdy = ($urandom_range(3) != 0);
        end
        RST = 1'b0; dreq_vld = 1'b0; kreq_vld = 1'b0; rsp_rdy = 1'b1;
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_sbox_scheduler.md
Name: cim_sbox_scheduler

Overview:
Shares one compute-in-memory S-box macro between two requesters: the cipher datapath (SubBytes, 16 bytes per request) and the key expansion unit (SubWord, 4 bytes per request).
- Arbitrates between the two requesters round-robin.
- Streams each request's bytes into the macro lanes two per cycle over a 16-bit bus.
- Triggers the lookup, waits the macro read latency, then captures and returns the substituted bytes.
- Sits between the AES round controller/key expander and the CIM macro wrapper.

Parameters:
RD_LAT, 1, cycles from cim_rd to valid cim_rio; legal range 1..7.
LANES, 16, number of macro lanes; fixed at 16.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
dreq_vld  in  1  datapath request valid
dreq_rdy  out  1  datapath request accepted this cycle
dreq_data  in  128  16 state bytes; byte0 = [127:120]
kreq_vld  in  1  key request valid
kreq_rdy  out  1  key request accepted this cycle
kreq_data  in  32  4 word bytes; byte0 = [31:24]
rsp_vld  out  1  result valid
rsp_rdy  in  1  result accepted
rsp_src  out  1  0 = datapath, 1 = key
rsp_data  out  128  substituted bytes; key result in [127:96], [95:0] = 0
cim_we  out  1  lane write strobe
cim_lane  out  4  first lane written (even)
cim_in  out  16  {byte lane n, byte lane n+1}
cim_rd  out  1  lookup trigger, one cycle
cim_rio  in  128  macro readback; lane0 = [127:120]
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is CLK. Reset is RST, synchronous and active-high.
- Reset values: every output is 0, the state is IDLE, and the round-robin pointer favours key.
- States: IDLE -> ISSUE -> LOOKUP -> WAIT -> RESP -> IDLE.
- IDLE arbitration:
  - Only one source is granted. Granted rdy = grant & vld & (state==IDLE). rdy is combinational.
  - Only one vld: that source wins.
  - Both vld: the pointer decides. The pointer flips to the other source after each grant.
  - On the handshake, the payload and source are registered and the state moves to ISSUE.
- ISSUE:
  - Datapath requests take 8 cycles; key requests take 2 cycles.
  - Cycle k drives cim_we=1, cim_lane=2k, cim_in={byte 2k, byte 2k+1}.
- LOOKUP: one cycle with cim_rd=1, cim_we=0.
- WAIT:
  - Counts RD_LAT cycles. The lookup cycle is L; cim_rio is sampled at the end of cycle L+RD_LAT.
  - Key requests take lanes 0..3 only; unused lanes are ignored.
- RESP:
  - rsp_vld=1 from cycle L+RD_LAT+1. rsp_data and rsp_src are held stable until rsp_rdy.
  - The state returns to IDLE on the cycle after rsp_vld&rsp_rdy.
  - A new request can be accepted in that IDLE cycle at the earliest. No overlap.
- Latency from handshake cycle T to first rsp_vld: datapath T+10+RD_LAT, key T+4+RD_LAT.
- Requests arriving while busy stay pending; the requester holds vld and data.
- RST mid-operation: the in-flight request is dropped with no response, all outputs go to 0, and the pointer resets.
- Simultaneous rsp_rdy and a new vld in RESP: the response completes and arbitration happens in the following IDLE cycle.
- The counter wraps only via the state transition. There is no modular reuse.

Decomposition:
- Package cim_sched_pkg holds:
  - the state enum (IDLE, ISSUE, LOOKUP, WAIT, RESP);
  - the source enum (SRC_DATA=0, SRC_KEY=1);
  - the issue-cycle constants (DATA_ISSUE=8, KEY_ISSUE=2);
  - LANES.
- One sub-module, cim_rr_arb: a 2-way round-robin arbiter with a pointer register, req[1:0] in, one-hot grant out, and an advance input.

Test Plan:
1. Datapath only, RD_LAT=1, dreq_data=00102030405060708090a0b0c0d0e0f0, bench macro models the AES S-box. Required: cim_lane goes 0,2..14 with cim_in 0010, 2030 through e0f0; cim_rd at T+9; rsp_vld at T+11 with rsp_data=63cab7040953d051cd60e0e7ba70e18c and rsp_src=0.
2. Key only, kreq_data=cf4f3c09. Required: two issue cycles (lanes 0 and 2), cim_rd at T+3, rsp_vld at T+5, rsp_data=8a84eb01_000...0, rsp_src=1.
3. dreq_vld and kreq_vld both asserted from reset. Required: key granted first, then datapath, then key again on the re-request; no source starves across 4 back-to-back pairs.
4. rsp_rdy held low for 5 cycles. Required: rsp_vld, rsp_data and rsp_src stable; dreq_rdy stays 0 throughout; IDLE is entered the cycle after acceptance.
5. RST pulsed during the 4th datapath issue cycle. Required: all outputs 0 on the next cycle, no response emitted, and the next simultaneous request grants key.
6. RD_LAT=3 rerun of scenario 1. Required: rsp_vld at T+13 with the same data.
